// File: rtl/snake_pixel_renderer.sv
// Purpose: tile-grid pixel colour generator for the snake display path; also derives
//          the game tick from frame arrivals and latches joystick direction.
// Latency: pixel_data/move_tick/mov_dir/dead_frame registered (1 cycle); grid_x/grid_y/cell_strobe combinational.
// Backpressure: none; streaming pixel path, one pixel per clk.
// Ports: clk/rst (sync, active-high); mov {up,left,down,right}; x,y pixel coordinate;
//        entity_data/dead from the snake controller; grid_x/grid_y tile coordinate;
//        cell_strobe in-tile phase pulse; move_tick game tick; mov_dir committed
//        direction (0 R,1 D,2 L,3 U); dead_frame border flash phase; pixel_data colour.
module snake_pixel_renderer #(
  parameter int COORD_W     = 9,
  parameter int CELL_LOG2   = 3,
  parameter int GRID_W      = 30,
  parameter int GRID_H      = 30,
  parameter int COLOR_W     = 16,
  parameter int TICK_FRAMES = 31,
  parameter int TICK_LINE   = 100,
  parameter int CELL_PHASE  = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 16'h0000,
  parameter logic [COLOR_W-1:0] OUT_COLOR    = 16'h0000,
  parameter logic [COLOR_W-1:0] DEAD_COLOR_1 = 16'hF800,
  parameter logic [COLOR_W-1:0] DEAD_COLOR_2 = 16'hFFE0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     mov,
  input  logic [COORD_W-1:0]             x,
  input  logic [COORD_W-1:0]             y,
  input  logic [COLOR_W-1:0]             entity_data,
  input  logic                           dead,
  output logic [COORD_W-CELL_LOG2-1:0]   grid_x,
  output logic [COORD_W-CELL_LOG2-1:0]   grid_y,
  output logic                           cell_strobe,
  output logic                           move_tick,
  output logic [1:0]                     mov_dir,
  output logic                           dead_frame,
  output logic [COLOR_W-1:0]             pixel_data
);

  localparam int GW    = COORD_W - CELL_LOG2;
  localparam int CNT_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [GW-1:0]        GRID_W_C   = GW'(GRID_W);
  localparam logic [GW-1:0]        GRID_H_C   = GW'(GRID_H);
  localparam logic [GW-1:0]        GRID_W_M1  = GW'(GRID_W - 1);
  localparam logic [GW-1:0]        GRID_H_M1  = GW'(GRID_H - 1);
  localparam logic [COORD_W-1:0]   TICK_LINE_C = COORD_W'(TICK_LINE);
  localparam logic [CELL_LOG2-1:0] PHASE_C    = CELL_LOG2'(CELL_PHASE);
  localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(TICK_FRAMES - 1);

  logic [COORD_W-1:0] y_q;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               move_tick_q, move_tick_d;
  logic [1:0]         pending_q, pending_d;
  logic [1:0]         mov_dir_q, mov_dir_d;
  logic               dead_q;
  logic               dead_frame_q, dead_frame_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;

  logic               frame_pulse;
  logic [1:0]         req_dir;
  logic               border;

  assign grid_x      = x[COORD_W-1:CELL_LOG2];
  assign grid_y      = y[COORD_W-1:CELL_LOG2];
  assign cell_strobe = (x[CELL_LOG2-1:0] == PHASE_C) && (y[CELL_LOG2-1:0] == PHASE_C);

  assign move_tick  = move_tick_q;
  assign mov_dir    = mov_dir_q;
  assign dead_frame = dead_frame_q;
  assign pixel_data = pixel_q;

  always_comb begin
    // Edge-detect on the tick line so a y held at TICK_LINE counts once.
    frame_pulse = (y == TICK_LINE_C) && (y_q != TICK_LINE_C);

    frame_cnt_d = frame_cnt_q;
    move_tick_d = 1'b0;
    if (frame_pulse) begin
      if (frame_cnt_q == CNT_MAX) begin
        frame_cnt_d = '0;
        move_tick_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Highest-index request wins: up > left > down > right.
    if (mov[3])      req_dir = 2'd3;
    else if (mov[2]) req_dir = 2'd2;
    else if (mov[1]) req_dir = 2'd1;
    else             req_dir = 2'd0;

    // Reversal is judged against the committed direction, not the pending one,
    // so two quarter-turns inside one tick cannot fold the snake back on itself.
    pending_d = pending_q;
    if ((|mov) && (req_dir != (mov_dir_q ^ 2'd2))) begin
      pending_d = req_dir;
    end

    mov_dir_d = move_tick_q ? pending_q : mov_dir_q;

    // Registered dead state gates the toggle: a tick coinciding with dead rising
    // does not flip the phase.
    dead_frame_d = 1'b0;
    if (dead_q) begin
      dead_frame_d = move_tick_q ? ~dead_frame_q : dead_frame_q;
    end

    border = (grid_x == '0) || (grid_x == GRID_W_M1) ||
             (grid_y == '0) || (grid_y == GRID_H_M1);

    if ((grid_x >= GRID_W_C) || (grid_y >= GRID_H_C)) begin
      pixel_d = OUT_COLOR;
    end else if (dead && border) begin
      pixel_d = dead_frame_q ? DEAD_COLOR_2 : DEAD_COLOR_1;
    end else if (dead) begin
      pixel_d = BG_COLOR;
    end else begin
      pixel_d = entity_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q          <= '0;
      frame_cnt_q  <= '0;
      move_tick_q  <= 1'b0;
      pending_q    <= 2'd0;
      mov_dir_q    <= 2'd0;
      dead_q       <= 1'b0;
      dead_frame_q <= 1'b0;
      pixel_q      <= '0;
    end else begin
      y_q          <= y;
      frame_cnt_q  <= frame_cnt_d;
      move_tick_q  <= move_tick_d;
      pending_q    <= pending_d;
      mov_dir_q    <= mov_dir_d;
      dead_q       <= dead;
      dead_frame_q <= dead_frame_d;
      pixel_q      <= pixel_d;
    end
  end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Purpose: self-checking bench for snake_pixel_renderer against a behavioural model.
// Latency: model predicts registered outputs one cycle after inputs are applied.
// Backpressure: none.
module tb_snake_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mov;
  logic [8:0]  x, y;
  logic [15:0] entity_data;
  logic        dead;
  logic [5:0]  grid_x, grid_y;
  logic        cell_strobe, move_tick, dead_frame;
  logic [1:0]  mov_dir;
  logic [15:0] pixel_data;

  snake_pixel_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .mov         (mov),
    .x           (x),
    .y           (y),
    .entity_data (entity_data),
    .dead        (dead),
    .grid_x      (grid_x),
    .grid_y      (grid_y),
    .cell_strobe (cell_strobe),
    .move_tick   (move_tick),
    .mov_dir     (mov_dir),
    .dead_frame  (dead_frame),
    .pixel_data  (pixel_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  // Behavioural model state: frames counted since reset, expected registered outputs.
  int          m_frames = 0;
  bit          m_tick = 0;
  bit          m_df = 0;
  bit          m_deadprev = 0;
  int          m_dir = 0;
  int          m_pend = 0;
  int          m_yprev = 0;
  logic [15:0] m_pix = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_color(input int px, input int py, input bit dd,
                                            input logic [15:0] ent, input bit df);
    int gx, gy;
    gx = px / 8;
    gy = py / 8;
    if (gx >= 30 || gy >= 30) return 16'h0000;
    if (dd && (gx == 0 || gx == 29 || gy == 0 || gy == 29)) return df ? 16'hFFE0 : 16'hF800;
    if (dd) return 16'h0000;
    return ent;
  endfunction

  // One clock cycle with the currently driven inputs; checks combinational
  // outputs before the edge and registered outputs after it.
  task automatic cyc();
    bit          frame, ntick, ndf, ndeadprev;
    int          nf, ndir, npend, d, nyprev;
    logic [15:0] npix;
    #1;
    check_val("grid_x", 32'(grid_x), 32'(int'(x) / 8));
    check_val("grid_y", 32'(grid_y), 32'(int'(y) / 8));
    check_val("cell_strobe", 32'(cell_strobe), 32'((int'(x) % 8 == 1) && (int'(y) % 8 == 1)));
    if (rst) begin
      nf = 0; ntick = 0; npend = 0; ndir = 0; ndf = 0; npix = 16'h0000;
      nyprev = 0; ndeadprev = 0;
    end else begin
      frame = (int'(y) == 100) && (m_yprev != 100);
      nf    = m_frames + (frame ? 1 : 0);
      ntick = frame && (nf % 31 == 0);
      npend = m_pend;
      if (mov != 4'b0000) begin
        d = 0;
        for (int b = 0; b < 4; b++) if (mov[b]) d = b;
        if (d != (m_dir + 2) % 4) npend = d;
      end
      ndir      = m_tick ? m_pend : m_dir;
      ndf       = m_deadprev ? (m_tick ? !m_df : m_df) : 1'b0;
      npix      = ref_color(int'(x), int'(y), dead, entity_data, m_df);
      nyprev    = int'(y);
      ndeadprev = dead;
    end
    @(posedge clk);
    #1;
    m_frames = nf; m_tick = ntick; m_pend = npend; m_dir = ndir;
    m_df = ndf; m_pix = npix; m_yprev = nyprev; m_deadprev = ndeadprev;
    check_val("pixel_data", 32'(pixel_data), 32'(m_pix));
    check_val("move_tick", 32'(move_tick), 32'(m_tick));
    check_val("mov_dir", 32'(mov_dir), 32'(m_dir));
    check_val("dead_frame", 32'(dead_frame), 32'(m_df));
    if (move_tick === 1'b1) ticks_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic short_frame();
    for (int i = 98; i <= 102; i++) begin
      y = 9'(i);
      x = 9'($urandom_range(0, 511));
      entity_data = 16'($urandom);
      cyc();
    end
  endtask

  task automatic run_to_tick();
    int start;
    start = ticks_seen;
    for (int f = 0; f < 40 && ticks_seen == start; f++) short_frame();
    check_val("tick_seen", 32'(ticks_seen - start), 32'd1);
  endtask

  initial begin
    int t0, yy;
    rst = 1'b1; mov = 4'b0000; x = '0; y = '0; entity_data = '0; dead = 1'b0;

    // Reset values
    do_reset();
    check_val("rst_pixel", 32'(pixel_data), 32'h0);
    check_val("rst_tick", 32'(move_tick), 32'h0);
    check_val("rst_dir", 32'(mov_dir), 32'h0);
    check_val("rst_dframe", 32'(dead_frame), 32'h0);

    // y stuck at the tick line: a single frame, no tick
    t0 = ticks_seen;
    y = 9'd100;
    repeat (300) begin x = 9'($urandom_range(0, 511)); cyc(); end
    check_val("stuck_ticks", 32'(ticks_seen - t0), 32'd0);

    // Full sweeps: exactly one tick after the 31st arrival
    do_reset();
    t0 = ticks_seen;
    for (int f = 0; f < 31; f++) begin
      for (int v = 0; v < 525; v++) begin
        y = 9'(v);
        x = 9'($urandom_range(0, 319));
        cyc();
      end
    end
    check_val("sweep_ticks", 32'(ticks_seen - t0), 32'd1);

    // Direction: reversal ignored, turn committed, priority
    do_reset();
    mov = 4'b0100; run_to_tick(); short_frame();
    check_val("dir_left_ignored", 32'(mov_dir), 32'd0);
    mov = 4'b0010; run_to_tick(); short_frame();
    check_val("dir_down", 32'(mov_dir), 32'd1);
    mov = 4'b0001; run_to_tick(); short_frame();
    check_val("dir_right", 32'(mov_dir), 32'd0);
    mov = 4'b1001; run_to_tick(); short_frame();
    check_val("dir_up_wins", 32'(mov_dir), 32'd3);
    mov = 4'b0000;

    // Colour select, alive
    dead = 1'b0; entity_data = 16'h07E0; x = 9'd17; y = 9'd9; cyc();
    check_val("alive_pixel", 32'(pixel_data), 32'h07E0);
    x = 9'd240; cyc();
    check_val("outside_pixel", 32'(pixel_data), 32'h0000);

    // Dead: border flashing and interior background
    do_reset();
    dead = 1'b1; x = 9'd0; y = 9'd40; cyc(); cyc();
    check_val("dead_border_1", 32'(pixel_data), 32'hF800);
    run_to_tick();
    x = 9'd0; y = 9'd40; cyc();
    check_val("dead_border_2", 32'(pixel_data), 32'hFFE0);
    run_to_tick();
    x = 9'd0; y = 9'd40; cyc();
    check_val("dead_border_3", 32'(pixel_data), 32'hF800);
    x = 9'd40; y = 9'd40; cyc();
    check_val("dead_interior", 32'(pixel_data), 32'h0000);
    x = 9'd0; y = 9'd0; cyc();
    check_val("dead_origin", 32'(pixel_data), 32'hF800);

    // Randomised phase against the model
    yy = 95;
    repeat (3000) begin
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) dead = ~dead;
      mov  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      x    = 9'($urandom_range(0, 511));
      entity_data = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        y = 9'($urandom_range(0, 511));
      end else begin
        y  = 9'(yy);
        yy = (yy == 105) ? 95 : yy + 1;
      end
      cyc();
    end
    rst = 1'b0; mov = 4'b0000;

    // Mid-frame reset with mov_dir=2 and dead_frame=1
    do_reset();
    dead = 1'b0;
    mov = 4'b0010; run_to_tick(); short_frame();
    mov = 4'b0100; run_to_tick(); short_frame();
    check_val("pre_rst_dir", 32'(mov_dir), 32'd2);
    mov = 4'b0000; dead = 1'b1;
    run_to_tick(); short_frame();
    check_val("pre_rst_dframe", 32'(dead_frame), 32'd1);
    x = 9'd0; y = 9'd50; cyc();
    check_val("pre_rst_pixel", 32'(pixel_data), 32'hFFE0);
    rst = 1'b1; cyc();
    check_val("mid_rst_pixel", 32'(pixel_data), 32'h0);
    check_val("mid_rst_tick", 32'(move_tick), 32'h0);
    check_val("mid_rst_dir", 32'(mov_dir), 32'h0);
    check_val("mid_rst_dframe", 32'(dead_frame), 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_pixel_renderer.md
# snake_pixel_renderer

Parametrised per-pixel colour generator for the snake display path. It maps VGA-style pixel coordinates onto a configurable tile grid and derives the per-frame game tick with a synchronous frame divider. It latches joystick direction with reversal rejection and produces the registered pixel colour: entity colour while alive, a flashing border when dead. It sits between the video timing generator and the LCD/VGA output, feeding grid coordinates, strobes and direction to the snake controller.

## Interface
- COORD_W, 9, width of x/y pixel coordinates
- CELL_LOG2, 3, log2 of tile edge in pixels (tile = 8×8 by default)
- GRID_W, 30, playfield width in tiles
- GRID_H, 30, playfield height in tiles
- COLOR_W, 16, pixel colour width
- TICK_FRAMES, 31, frames per game tick (tick period = TICK_FRAMES frames)
- TICK_LINE, 100, y value whose arrival marks one frame
- CELL_PHASE, 1, in-tile x/y offset at which cell_strobe fires
- BG_COLOR, 16'h0000; OUT_COLOR, 16'h0000; DEAD_COLOR_1, 16'hF800; DEAD_COLOR_2, 16'hFFE0

- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mov  in  4  direction requests {up, left, down, right}, level
- x, y  in  COORD_W  current pixel coordinate
- entity_data  in  COLOR_W  colour from snake controller for current tile
- dead  in  1  game-over flag from snake controller
- grid_x, grid_y  out  COORD_W-CELL_LOG2  combinational tile coordinate (x>>CELL_LOG2, y>>CELL_LOG2)
- cell_strobe  out  1  combinational; high when x and y low CELL_LOG2 bits both equal CELL_PHASE
- move_tick  out  1  registered one-cycle game-tick pulse
- mov_dir  out  2  committed direction: 0 right, 1 down, 2 left, 3 up
- dead_frame  out  1  border flash phase
- pixel_data  out  COLOR_W  registered pixel colour

## Operation
- Frame detect: register y; frame_pulse = (y == TICK_LINE) && (y_q != TICK_LINE). No derived clocks.
- Frame counter: 0..TICK_FRAMES-1, increments on frame_pulse, wraps to 0. move_tick asserted in the cycle after a frame_pulse that wraps the counter to 0.
- Direction request: pending_dir updates every cycle any mov bit is set. With multiple bits set, highest index wins (up > left > down > right). A request equal to mov_dir XOR 2 (reversal) is ignored.
- Commit: on move_tick, mov_dir <= pending_dir. Reversal check is against the committed mov_dir, so two-step turns within one tick cannot reverse.
- dead_frame toggles on each move_tick while dead=1; cleared when dead=0.
- Colour select (priority high→low):
  - grid_x ≥ GRID_W or grid_y ≥ GRID_H: OUT_COLOR
  - dead and border tile (grid_x∈{0,GRID_W-1} or grid_y∈{0,GRID_H-1}): DEAD_COLOR_2 if dead_frame else DEAD_COLOR_1
  - dead, interior: BG_COLOR
  - alive: entity_data
- Outside-grid test applies to every pixel including (0,0). No special case at frame boundaries.

## Timing
- pixel_data: 1-cycle latency from x, y, entity_data, dead.
- move_tick: exactly one cycle wide, period TICK_FRAMES frames.
- mov_dir changes only in the cycle after move_tick.
- Reset values: pixel_data=0, move_tick=0, mov_dir=0, pending_dir=0, dead_frame=0, frame counter=0, y_q=0.
- Reset mid-frame: all state returns to reset values next edge; frame counting restarts at the next TICK_LINE arrival.
- Simultaneous mov request and move_tick in the same cycle: the commit uses the old pending_dir; the new request lands in pending_dir and commits at the following tick.
- y held at TICK_LINE for many cycles counts as a single frame.
- dead rising on the same cycle as move_tick: no toggle on that tick, since the toggle samples registered dead state.

## Test plan
- Reset, then y sweeps 0..524 for 31 frames -> exactly one move_tick, one cycle wide, after the 31st TICK_LINE arrival. Zero ticks with y stuck at 100.
- mov_dir=0, assert mov=4'b0100 (left) -> pending ignored, mov_dir stays 0 after tick. Assert mov=4'b0010 -> mov_dir=1 after next tick.
- mov=4'b1001 -> pending=3 (up wins). Commit on tick gives mov_dir=3.
- dead=0, entity_data=16'h07E0, x=17, y=9 -> pixel_data=16'h07E0 one cycle later. At x=240 (grid_x=30) -> OUT_COLOR.
- dead=1 -> at grid (0,5): 16'hF800, then 16'hFFE0 after the next move_tick, then alternating. Grid (5,5) shows BG_COLOR. At x=0, y=0 -> border colour on every frame, no black glitch.
- Assert rst mid-frame with mov_dir=2, dead_frame=1 -> next cycle all outputs at reset values.
